// File: rtl/tim_prescaler.sv
// Even-integer clock prescaler: divides clk_i by a sanitised even ratio into a
// 50 % duty clock plus a one-cycle tick on each rising edge. A new ratio is
// taken over a valid/ready handshake and applied at the next falling edge.
module tim_prescaler #(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 div_done_o,
    output logic                 clk_o,
    output logic                 tick_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [DIV_WIDTH-2:0] half_q;
    logic [DIV_WIDTH-2:0] pend_q;
    logic [DIV_WIDTH-2:0] cnt_q;
    logic [DIV_WIDTH-2:0] half_m1;
    logic                 clk_q;
    logic                 tick_q;
    logic                 accept;
    logic                 toggle;
    logic                 fall;

    // Half period of the sanitised ratio: values below 2 become 2, odd values
    // round down, so the half is simply the upper bits (minimum 1).
    function automatic logic [DIV_WIDTH-2:0] sanitise_half(input logic [DIV_WIDTH-1:0] d);
        if (d[DIV_WIDTH-1:1] == '0) begin
            return (DIV_WIDTH-1)'(1);
        end
        return d[DIV_WIDTH-1:1];
    endfunction

    assign half_m1     = half_q - (DIV_WIDTH-1)'(1);
    assign div_ready_o = (state_q != SWITCH);
    assign div_done_o  = (state_q == RUN);
    assign clk_o       = clk_q;
    assign tick_o      = tick_q;
    assign accept      = div_valid_i && div_ready_o;
    // The counter only runs once a ratio is committed; it never passes half-1.
    assign toggle      = (state_q != IDLE) && (cnt_q == half_m1);
    assign fall        = toggle && clk_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: a pending ratio is only committed on a falling edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (accept) state_d = SWITCH;
            SWITCH:  if (fall)   state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Divider datapath: half-period counter, divided clock, tick and ratio regs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            half_q <= '0;
            pend_q <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= toggle && !clk_q;
            case (state_q)
                IDLE: begin
                    clk_q <= 1'b0;
                    cnt_q <= '0;
                    if (accept) begin
                        half_q <= sanitise_half(div_i);
                    end
                end
                RUN: begin
                    if (accept) begin
                        pend_q <= sanitise_half(div_i);
                    end
                    if (toggle) begin
                        cnt_q <= '0;
                        clk_q <= ~clk_q;
                    end else begin
                        cnt_q <= cnt_q + (DIV_WIDTH-1)'(1);
                    end
                end
                SWITCH: begin
                    if (fall) begin
                        // Swap ratios exactly as the low phase begins so the
                        // high phase just finished keeps its full old width.
                        half_q <= pend_q;
                        cnt_q  <= '0;
                        clk_q  <= 1'b0;
                    end else if (toggle) begin
                        cnt_q <= '0;
                        clk_q <= ~clk_q;
                    end else begin
                        cnt_q <= cnt_q + (DIV_WIDTH-1)'(1);
                    end
                end
                default: begin
                    cnt_q <= '0;
                    clk_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tim_prescaler.sv
// Bench for tim_prescaler: a time-based reference model predicts every cycle's
// outputs; predictions are queued by the driver and checked by a monitor.
module tb_tim_prescaler;

  logic        clk;
  logic        rst;
  logic [31:0] div;
  logic        div_valid;
  logic        div_ready;
  logic        div_done;
  logic        clk_div;
  logic        tick;

  tim_prescaler #(.DIV_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .div_i       (div),
    .div_valid_i (div_valid),
    .div_ready_o (div_ready),
    .div_done_o  (div_done),
    .clk_o       (clk_div),
    .tick_o      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {clk_o, tick_o, div_done_o, div_ready_o} per cycle.
  logic [3:0] expq[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Reference model in absolute cycle numbers: once a ratio with half h
  // starts at cycle S (clk_o low), clk_o in cycle c is high when
  // floor((c-S)/h) is odd. A pending ratio takes over at cycle F, the first
  // falling-edge cycle S+2mh that is at least two cycles after the accept.
  longint     k;
  bit         m_act;
  bit         m_pend;
  longint     m_s;
  longint     m_h;
  longint     m_ph;
  longint     m_f;
  bit         last_acc;
  logic [3:0] cur;

  function automatic longint san(input logic [31:0] d);
    if (d < 32'd2) return 1;
    return longint'(d >> 1);
  endfunction

  function void advance(input longint c);
    if (m_pend && c >= m_f) begin
      m_s    = m_f;
      m_h    = m_ph;
      m_pend = 1'b0;
    end
  endfunction

  function bit clk_at(input longint c);
    return (((c - m_s) / m_h) % 2) == 1;
  endfunction

  function logic [3:0] expect_at(input longint c);
    bit ck;
    bit tk;
    if (!m_act) return 4'b0001;
    ck = clk_at(c);
    tk = ck && (((c - m_s) % m_h) == 0);
    return {ck, tk, !m_pend, !m_pend};
  endfunction

  // One clk_i cycle of stimulus; inputs apply to cycle k.
  task automatic step(input bit r, input bit v, input logic [31:0] d);
    longint m;
    @(negedge clk);
    rst       = r;
    div_valid = v;
    div       = d;
    advance(k);
    last_acc = 1'b0;
    if (r) begin
      m_act  = 1'b0;
      m_pend = 1'b0;
    end else if (v && (!m_act || !m_pend)) begin
      last_acc = 1'b1;
      if (!m_act) begin
        m_act = 1'b1;
        m_s   = k + 1;
        m_h   = san(d);
      end else begin
        m_pend = 1'b1;
        m_ph   = san(d);
        m = (k + 2 - m_s + 2 * m_h - 1) / (2 * m_h);
        if (m < 1) m = 1;
        m_f = m_s + 2 * m * m_h;
      end
    end
    k = k + 1;
    advance(k);
    cur = expect_at(k);
    expq.push_back(cur);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && m_act && m_pend; i++) step(1'b0, 1'b0, 32'd0);
    n_checks++;
    if (!(m_act && m_pend) && (div_ready === !(m_act && m_pend))) n_pass++;
    else $display("FAIL wait_ready expired or ready mismatch t=%0t ready=%b pend=%0d", $time, div_ready, m_pend);
  endtask

  // Monitor: compare the outputs of every cycle against the queued prediction.
  initial begin
    forever begin
      logic [3:0] got;
      logic [3:0] exp_v;
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        exp_v = expq.pop_front();
        got   = {clk_div, tick, div_done, div_ready};
        n_checks++;
        if (got === exp_v) n_pass++;
        else $display("FAIL outs t=%0t clk/tick/done/ready got=%b required=%b", $time, got, exp_v);
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    rst       = 1'b1;
    div_valid = 1'b0;
    div       = '0;
    k         = 0;
    m_act     = 1'b0;
    m_pend    = 1'b0;
    m_s       = 0;
    m_h       = 1;
    m_ph      = 1;
    m_f       = 0;
    last_acc  = 1'b0;
    cur       = 4'b0001;

    // Reset held, then quiet with no ratio applied.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    n_checks++;
    if ({clk_div, tick, div_done, div_ready} === 4'b0001) n_pass++;
    else $display("FAIL reset state t=%0t clk/tick/done/ready got=%b required=0001", $time,
                  {clk_div, tick, div_done, div_ready});
    while (k < 10) step(1'b0, 1'b0, 32'd0);

    // Basic divide by 4.
    step(1'b0, 1'b1, 32'd4);
    idle(16);

    // Switch 4 -> 10 while clk_o is high.
    for (int i = 0; i < 50 && cur[3] != 1'b1; i++) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'd10);
    idle(40);

    // Sanitising: 0, 1 and 7.
    wait_ready();
    step(1'b0, 1'b1, 32'd0);
    idle(24);
    wait_ready();
    step(1'b0, 1'b1, 32'd1);
    idle(12);
    wait_ready();
    step(1'b0, 1'b1, 32'd7);
    idle(30);

    // Busy: valid held with 12 through a switch; accepted exactly once.
    wait_ready();
    step(1'b0, 1'b1, 32'd6);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1, 32'd12);
      if (last_acc) break;
    end
    idle(40);

    // Accept coinciding with a falling toggle.
    wait_ready();
    for (int i = 0; i < 60; i++) begin
      if (!m_pend && clk_at(k) && !clk_at(k + 1)) break;
      step(1'b0, 1'b0, 32'd0);
    end
    step(1'b0, 1'b1, 32'd8);
    idle(36);

    // Reset during SWITCH with 8 pending: nothing applied after release.
    wait_ready();
    step(1'b0, 1'b1, 32'd8);
    step(1'b1, 1'b0, 32'd0);
    idle(25);

    // Widest ratio: committed but never toggles within the run.
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    idle(10);
    step(1'b1, 1'b0, 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
           32'($urandom_range(0, 13)));
    end
    idle(4);

    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
